// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: default vectors and
// the next-PC source encoding.
package pc_pkg;

  // Default handler/reset vectors (32-bit core; kernel bit set).
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  // Where the next fetch PC comes from.
  typedef enum logic [3:0] {
    SEQ,    // PC + 4
    BR,     // taken conditional branch
    JMP,    // J/JAL
    JR,     // JR/JALR
    PEND,   // redirect queued during a stall
    ILLOP,  // illegal-instruction vector
    XADR,   // interrupt vector
    ERET,   // return to EPC
    HOLD    // fetch stalled
  } pc_src_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: priority-encodes the event inputs into a source and
// forms the corresponding target, plus the redirect target to queue while
// fetch is stalled.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] ILLOP_VEC = pc_pkg::ILLOP_VEC,
  parameter logic [XLEN-1:0] XADR_VEC  = pc_pkg::XADR_VEC
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            pending_valid,
  input  logic [XLEN-1:0] pending_target,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [25:0]     jmp_index,
  input  logic            jr_valid,
  input  logic [XLEN-1:0] jr_target,
  input  logic            illop,
  input  logic            irq,
  input  logic            eret,
  output pc_src_e         src,
  output logic [XLEN-1:0] next_pc,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_target,
  output logic [XLEN-1:0] pc_plus4
);

  logic            kernel;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] jmp_pc;
  logic [XLEN-1:0] jr_pc;

  assign kernel = pc[XLEN-1];

  // Increment only the low bits so the kernel bit can never be carried into.
  assign pc_plus4 = {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};

  // Branch keeps the current privilege; jump stays in the current 256 MB region.
  assign br_pc  = {pc[XLEN-1], br_target[XLEN-2:0]};
  assign jmp_pc = {pc[XLEN-1:28], jmp_index, 2'b00};

  // User code may not reach kernel space through a register jump.
  assign jr_pc  = {jr_target[XLEN-1] & kernel, jr_target[XLEN-2:2], 2'b00};

  // Resolve the highest-priority redirect among jr > jmp > taken branch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and infers a latch.
    redir_valid  = 1'b1;
    redir_target = pc_plus4;
    if (jr_valid)                  redir_target = jr_pc;
    else if (jmp_valid)            redir_target = jmp_pc;
    else if (br_valid && br_taken) redir_target = br_pc;
    else                           redir_valid  = 1'b0;
  end

  // Pick the next-PC source by event priority and form its value.
  always_comb begin
    src     = SEQ;
    next_pc = pc_plus4;
    if (illop) begin
      src     = ILLOP;
      next_pc = ILLOP_VEC;
    end else if (irq && !kernel) begin
      src     = XADR;
      next_pc = XADR_VEC;
    end else if (eret) begin
      src     = ERET;
      next_pc = epc;
    end else if (stall) begin
      src     = HOLD;
      next_pc = pc;
    end else if (pending_valid) begin
      src     = PEND;
      next_pc = pending_target;
    end else if (redir_valid) begin
      next_pc = redir_target;
      if (jr_valid)       src = JR;
      else if (jmp_valid) src = JMP;
      else                src = BR;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch program counter for the pipelined MIPS core: holds PC, EPC, the
// stalled-redirect queue and the flush flag; next-PC selection lives in
// pc_next_mux.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = pc_pkg::RESET_VEC,
  parameter logic [XLEN-1:0] ILLOP_VEC = pc_pkg::ILLOP_VEC,
  parameter logic [XLEN-1:0] XADR_VEC  = pc_pkg::XADR_VEC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_valid_i,
  input  logic [25:0]     jmp_index_i,
  input  logic            jr_valid_i,
  input  logic [XLEN-1:0] jr_target_i,
  input  logic            illop_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            eret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] epc_o,
  output logic            kernel_o,
  output logic            flush_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            pending_valid_q;
  logic [XLEN-1:0] pending_target_q;
  logic            flush_q;

  pc_src_e         src;
  logic [XLEN-1:0] next_pc;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            take_exc;
  logic            clear_pending;
  logic            capture_pending;
  logic            non_seq;

  pc_next_mux #(
    .XLEN      (XLEN),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_next (
    .pc             (pc_q),
    .epc            (epc_q),
    .pending_valid  (pending_valid_q),
    .pending_target (pending_target_q),
    .stall          (stall_i),
    .br_valid       (br_valid_i),
    .br_taken       (br_taken_i),
    .br_target      (br_target_i),
    .jmp_valid      (jmp_valid_i),
    .jmp_index      (jmp_index_i),
    .jr_valid       (jr_valid_i),
    .jr_target      (jr_target_i),
    .illop          (illop_i),
    .irq            (irq_i),
    .eret           (eret_i),
    .src            (src),
    .next_pc        (next_pc),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .pc_plus4       (pc_plus4_o)
  );

  // Decode the selected source into register update controls.
  always_comb begin
    take_exc        = (src == ILLOP) || (src == XADR);
    clear_pending   = take_exc || (src == ERET) || (src == PEND);
    // Only the first redirect seen during a stall is kept; later ones are wrong-path.
    capture_pending = (src == HOLD) && !pending_valid_q && redir_valid;
    non_seq         = (src != SEQ) && (src != HOLD);
  end

  // PC, EPC, pending redirect and flush registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_VEC;
      epc_q            <= '0;
      pending_valid_q  <= 1'b0;
      // NOTE: the pending target is a plain register, not storage, so it is
      // reset along with its valid bit.
      pending_target_q <= '0;
      flush_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      pc_q    <= next_pc;
      flush_q <= non_seq;
      if (take_exc) epc_q <= exc_pc_i;
      if (clear_pending) begin
        pending_valid_q <= 1'b0;
      end else if (capture_pending) begin
        pending_valid_q  <= 1'b1;
        pending_target_q <= redir_target;
      end
    end
  end

  assign pc_o     = pc_q;
  assign epc_o    = epc_q;
  assign kernel_o = pc_q[XLEN-1];
  assign flush_o  = flush_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, sequential fetch, JR/J/branch
// redirects, stalled redirect queueing, interrupts, illegal ops, eret,
// wrap-around and asynchronous reset during a stall.
module tb_pc_fetch_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i;
  logic            br_valid_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            jmp_valid_i;
  logic [25:0]     jmp_index_i;
  logic            jr_valid_i;
  logic [XLEN-1:0] jr_target_i;
  logic            illop_i;
  logic            irq_i;
  logic [XLEN-1:0] exc_pc_i;
  logic            eret_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic [XLEN-1:0] epc_o;
  logic            kernel_o;
  logic            flush_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_fetch_ctrl #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .jmp_valid_i (jmp_valid_i),
    .jmp_index_i (jmp_index_i),
    .jr_valid_i  (jr_valid_i),
    .jr_target_i (jr_target_i),
    .illop_i     (illop_i),
    .irq_i       (irq_i),
    .exc_pc_i    (exc_pc_i),
    .eret_i      (eret_i),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .epc_o       (epc_o),
    .kernel_o    (kernel_o),
    .flush_o     (flush_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    stall_i     = 1'b0;
    br_valid_i  = 1'b0;
    br_taken_i  = 1'b0;
    br_target_i = '0;
    jmp_valid_i = 1'b0;
    jmp_index_i = '0;
    jr_valid_i  = 1'b0;
    jr_target_i = '0;
    illop_i     = 1'b0;
    irq_i       = 1'b0;
    exc_pc_i    = '0;
    eret_i      = 1'b0;

    // Reset state and sequential fetch
    step();
    step();
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_epc", epc_o, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    check("rst_kernel", {31'b0, kernel_o}, 32'h1);
    check("rst_plus4", pc_plus4_o, 32'h8000_0004);
    reset = 1'b0;
    step();
    check("seq1", pc_o, 32'h8000_0004);
    check("seq1_flush", {31'b0, flush_o}, 32'h0);
    step();
    check("seq2", pc_o, 32'h8000_0008);
    step();
    check("seq3", pc_o, 32'h8000_000C);
    check("seq3_flush", {31'b0, flush_o}, 32'h0);

    // Kernel JR into user space, kernel bit taken from target
    jr_valid_i = 1'b1;
    jr_target_i = 32'h0000_1000;
    step();
    check("kjr_pc", pc_o, 32'h0000_1000);
    check("kjr_kernel", {31'b0, kernel_o}, 32'h0);
    check("kjr_flush", {31'b0, flush_o}, 32'h1);

    // User JR to kernel address: kernel bit and low bits cleared
    jr_target_i = 32'h8000_2003;
    step();
    check("ujr_pc", pc_o, 32'h0000_2000);
    check("ujr_flush", {31'b0, flush_o}, 32'h1);
    jr_valid_i = 1'b0;
    step();
    check("ujr_seq", pc_o, 32'h0000_2004);
    check("ujr_seq_flush", {31'b0, flush_o}, 32'h0);

    // Stall with queued branch; later jump during the stall is dropped
    stall_i = 1'b1;
    br_valid_i = 1'b1;
    br_taken_i = 1'b1;
    br_target_i = 32'h0000_4000;
    step();
    check("stall1_pc", pc_o, 32'h0000_2004);
    check("stall1_flush", {31'b0, flush_o}, 32'h0);
    br_valid_i = 1'b0;
    br_taken_i = 1'b0;
    jmp_valid_i = 1'b1;
    jmp_index_i = 26'h000_0800;
    step();
    check("stall2_pc", pc_o, 32'h0000_2004);
    jmp_valid_i = 1'b0;
    step();
    check("stall3_pc", pc_o, 32'h0000_2004);
    stall_i = 1'b0;
    step();
    check("pend_pc", pc_o, 32'h0000_4000);
    check("pend_flush", {31'b0, flush_o}, 32'h1);
    step();
    check("pend_seq", pc_o, 32'h0000_4004);
    check("pend_seq_flush", {31'b0, flush_o}, 32'h0);

    // Not-taken branch is a sequential step
    br_valid_i = 1'b1;
    br_target_i = 32'h0000_9000;
    step();
    check("br_nt_pc", pc_o, 32'h0000_4008);
    check("br_nt_flush", {31'b0, flush_o}, 32'h0);
    br_valid_i = 1'b0;

    // Interrupt from user, overriding a stall; ignored in kernel; eret
    jr_valid_i = 1'b1;
    jr_target_i = 32'h0000_0100;
    step();
    check("jr100", pc_o, 32'h0000_0100);
    jr_valid_i = 1'b0;
    irq_i = 1'b1;
    exc_pc_i = 32'h0000_0104;
    stall_i = 1'b1;
    step();
    check("irq_pc", pc_o, 32'h8000_0008);
    check("irq_epc", epc_o, 32'h0000_0104);
    check("irq_kernel", {31'b0, kernel_o}, 32'h1);
    check("irq_flush", {31'b0, flush_o}, 32'h1);
    stall_i = 1'b0;
    exc_pc_i = 32'h0000_0AAA;
    step();
    check("irq_nest_pc", pc_o, 32'h8000_000C);
    check("irq_nest_epc", epc_o, 32'h0000_0104);
    check("irq_nest_flush", {31'b0, flush_o}, 32'h0);
    irq_i = 1'b0;
    eret_i = 1'b1;
    step();
    check("eret_pc", pc_o, 32'h0000_0104);
    check("eret_kernel", {31'b0, kernel_o}, 32'h0);
    check("eret_flush", {31'b0, flush_o}, 32'h1);
    eret_i = 1'b0;

    // Jump keeps the upper PC region
    jmp_valid_i = 1'b1;
    jmp_index_i = 26'h000_1234;
    step();
    check("jmp_pc", pc_o, 32'h0000_48D0);
    jmp_valid_i = 1'b0;

    // Illegal op from user, then illop with JR together in kernel
    illop_i = 1'b1;
    exc_pc_i = 32'h0000_48D0;
    step();
    check("illop_pc", pc_o, 32'h8000_0004);
    check("illop_epc", epc_o, 32'h0000_48D0);
    jr_valid_i = 1'b1;
    jr_target_i = 32'h0000_5000;
    exc_pc_i = 32'h1111_1110;
    step();
    check("illop_k_pc", pc_o, 32'h8000_0004);
    check("illop_k_epc", epc_o, 32'h1111_1110);
    illop_i = 1'b0;

    // Low-bit wrap in user space
    jr_target_i = 32'h7FFF_FFFC;
    step();
    check("wrap_u_at", pc_o, 32'h7FFF_FFFC);
    check("wrap_u_plus4", pc_plus4_o, 32'h0000_0000);
    jr_valid_i = 1'b0;
    step();
    check("wrap_u_pc", pc_o, 32'h0000_0000);

    // Low-bit wrap in kernel space keeps the kernel bit
    illop_i = 1'b1;
    step();
    illop_i = 1'b0;
    jr_valid_i = 1'b1;
    jr_target_i = 32'hFFFF_FFFC;
    step();
    check("wrap_k_at", pc_o, 32'hFFFF_FFFC);
    jr_valid_i = 1'b0;
    step();
    check("wrap_k_pc", pc_o, 32'h8000_0000);
    check("wrap_k_kernel", {31'b0, kernel_o}, 32'h1);

    // Asynchronous reset while a redirect is pending
    step();
    check("pre_rst_pc", pc_o, 32'h8000_0004);
    stall_i = 1'b1;
    jr_valid_i = 1'b1;
    jr_target_i = 32'h0000_6000;
    step();
    check("pre_rst_hold", pc_o, 32'h8000_0004);
    jr_valid_i = 1'b0;
    reset = 1'b1;
    #2;
    check("async_rst_pc", pc_o, 32'h8000_0000);
    check("async_rst_epc", epc_o, 32'h0);
    step();
    reset = 1'b0;
    stall_i = 1'b0;
    step();
    check("post_rst_pc", pc_o, 32'h8000_0004);
    check("post_rst_flush", {31'b0, flush_o}, 32'h0);
    step();
    check("post_rst_seq", pc_o, 32'h8000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
